// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle signed divider: FSM encoding, default sizing and latency.
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 6;
    // Start edge to the edge that raises data_resultRDY for a non-zero divisor.
    localparam int unsigned DIV_LATENCY   = DEFAULT_WIDTH + 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One non-restoring iteration: shift the partial remainder, then add or subtract the divisor
// depending on the sign of the previous partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] d_ext;

    always_comb begin
        r_sh  = {r_in[WIDTH-1:0], q_msb};
        d_ext = {1'b0, divisor};
        r_out = r_in[WIDTH] ? (r_sh + d_ext) : (r_sh - d_ext);
        q_bit = ~r_out[WIDTH];
    end

endmodule

// File: rtl/div_32.sv
// Multi-cycle signed divider, one quotient bit per clock (non-restoring).
// Optional remainder output enabled by `define DIV_REMAINDER_EN.
module div_32
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             quot_neg_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic [WIDTH:0]   r_step;
    logic             q_bit;

    // |-2^WIDTH-1| wraps to itself, which is the correct unsigned magnitude.
    assign a_mag  = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign b_mag  = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    assign b_zero = (data_operandB == '0);

`ifdef DIV_REMAINDER_EN
    logic           rem_neg_q;
    logic [WIDTH:0] r_fix;

    assign r_fix = r_q[WIDTH] ? (r_q + {1'b0, dvsr_q}) : r_q;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r_in   (r_q),
        .q_msb  (q_q[WIDTH-1]),
        .divisor(dvsr_q),
        .r_out  (r_step),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            r_q            <= '0;
            q_q            <= '0;
            dvsr_q         <= '0;
            quot_neg_q     <= 1'b0;
            zero_q         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_neg_q      <= 1'b0;
            data_remainder <= '0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            unique case (state_q)
                // busy stays high through the RDY cycle, which is spent in StIdle.
                StIdle: busy <= 1'b0;
                StRun: begin
                    r_q   <= r_step;
                    q_q   <= {q_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    q_q     <= quot_neg_q ? (~q_q + 1'b1) : q_q;
`ifdef DIV_REMAINDER_EN
                    r_q     <= rem_neg_q ? (~r_fix + 1'b1) : r_fix;
`endif
                    state_q <= StDone;
                end
                StDone: begin
                    data_result    <= q_q;
                    data_exception <= zero_q;
                    data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
                    data_remainder <= r_q[WIDTH-1:0];
`endif
                    state_q        <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // A start in any state restarts; outputs of a completing op are already committed above.
            if (ctrl_DIV) begin
                cnt_q      <= '0;
                r_q        <= '0;
                q_q        <= b_zero ? '0 : a_mag;
                dvsr_q     <= b_mag;
                quot_neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                zero_q     <= b_zero;
                busy       <= 1'b1;
                state_q    <= b_zero ? StDone : StRun;
`ifdef DIV_REMAINDER_EN
                rem_neg_q  <= data_operandA[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_div_32.sv
// Scoreboard bench for div_32: directed and random divides, abort, reset and boundary cases.
module tb_div_32;
    import div_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;
`ifdef DIV_REMAINDER_EN
    logic [W-1:0] data_remainder;
`endif

    div_32 dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
`ifdef DIV_REMAINDER_EN
        .data_remainder(data_remainder),
`endif
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        logic [W-1:0] rem;
        int unsigned  start;
        int unsigned  lat;
        int unsigned  id;
    } exp_t;

    exp_t        sb[$];
    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned op_id  = 0;

    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return '0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
    endfunction

    function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return '0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return $signed(a) % $signed(b);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drives one start pulse; the sampling edge becomes cycle 'cyc' seen right after it.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_rdy);
        exp_t e;
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        if (expect_rdy) begin
            op_id++;
            e.res   = model_q(a, b);
            e.exc   = (b == '0);
            e.rem   = model_r(a, b);
            e.start = cyc;
            e.lat   = (b == '0) ? 1 : DIV_LATENCY;
            e.id    = op_id;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int unsigned max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        chk("drain_timeout", W'(sb.size()), '0);
    endtask

    always @(negedge clock) begin
        if (data_resultRDY) begin
            exp_t e;
            chk("rdy_expected", W'(sb.size() != 0), W'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("op%0d_result", e.id), data_result, e.res);
                chk($sformatf("op%0d_exception", e.id), W'(data_exception), W'(e.exc));
                chk($sformatf("op%0d_latency", e.id), W'(cyc - e.start), W'(e.lat));
                chk($sformatf("op%0d_busy_in_rdy", e.id), W'(busy), W'(1));
`ifdef DIV_REMAINDER_EN
                chk($sformatf("op%0d_remainder", e.id), data_remainder, e.rem);
`endif
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        #1 reset = 1'b1;
        #1;
        chk("reset_result", data_result, '0);
        chk("reset_exception", W'(data_exception), '0);
        chk("reset_rdy", W'(data_resultRDY), '0);
        chk("reset_busy", W'(busy), '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Basic signs.
        start_op(32'd100, 32'd7, 1'b1);
        drain(60);
        start_op(-32'sd100, 32'd7, 1'b1);
        drain(60);
        start_op(32'd100, -32'sd7, 1'b1);
        drain(60);

        // Divide by zero, then busy must drop.
        start_op(32'd5, 32'd0, 1'b1);
        drain(10);
        @(negedge clock);
        chk("div0_busy_after", W'(busy), '0);

        // Overflow and most-negative magnitude.
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        drain(60);
        start_op(32'h8000_0000, 32'd1, 1'b1);
        drain(60);

        // Abort: restart at clock 10 of a divide; only the second completes.
        start_op(32'd50, 32'd5, 1'b0);
        repeat (9) @(posedge clock);
        start_op(32'd9, 32'd3, 1'b1);
        drain(60);

        // Start during the DONE cycle: both ops must report.
        start_op(32'd1000, 32'd9, 1'b1);
        repeat (33) @(posedge clock);
        #1;
        start_op(32'd20, -32'sd6, 1'b1);
        drain(100);

        // Asynchronous reset mid-divide.
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (14) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("midreset_result", data_result, '0);
        chk("midreset_exception", W'(data_exception), '0);
        chk("midreset_rdy", W'(data_resultRDY), '0);
        chk("midreset_busy", W'(busy), '0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(posedge clock);
        start_op(32'd7, 32'd2, 1'b1);
        drain(60);

        // Random operands, divisor magnitude spread by shifting.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rb = $signed(rb) >>> $urandom_range(0, 30);
            start_op(ra, rb, 1'b1);
            drain(60);
        end

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
